// File: rtl/gfx_pkg.sv
// Shared definitions for the graphics adapter: register map, display modes,
// control/status bit positions and text geometry defaults.
package gfx_pkg;

   localparam logic [3:0] REG_MODE    = 4'd0;
   localparam logic [3:0] REG_DATA    = 4'd1;
   localparam logic [3:0] REG_ADDR_LO = 4'd3;
   localparam logic [3:0] REG_ADDR_HI = 4'd4;
   localparam logic [3:0] REG_STATUS  = 4'd5;

   typedef enum logic [1:0] {
      MODE_MTXT = 2'd0,
      MODE_CTXT = 2'd1,
      MODE_LBMP = 2'd2,
      MODE_HBMP = 2'd3
   } disp_mode_e;

   // MODE[1] doubles as the linear-addressing select (both bitmap modes)
   localparam int unsigned MODE_LINEAR_BIT   = 1;
   localparam int unsigned MODE_AUTOINC_BIT  = 7;
   localparam int unsigned STATUS_VBLANK_BIT = 0;
   localparam int unsigned STATUS_PEND_BIT   = 7;

   localparam int unsigned COLS_DEF = 80;
   localparam int unsigned ROWS_DEF = 60;

   typedef enum logic [1:0] {
      WR_IDLE   = 2'd0,
      WR_STROBE = 2'd1,
      WR_INC    = 2'd2
   } wr_state_e;

   function automatic logic [15:0] xy_addr(input logic [7:0] row, input logic [6:0] col);
      return {1'b0, row, col};
   endfunction

endpackage

// File: rtl/bus_sync.sv
// Multi-stage flip-flop synchronizer for a bundle of asynchronous host bus
// signals; all stages clear on reset.
module bus_sync
   import gfx_pkg::*;
#(
   parameter int unsigned WIDTH  = 1,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < STAGES; i++) stage[i] <= '0;
      end else begin
         stage[0] <= d;
         for (int unsigned i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[STAGES-1];

endmodule

// File: rtl/host_reg_if.sv
// Host bus front end: synchronizes 1 MHz host cycles into the fabric clock,
// holds the control registers and turns DATA writes into screen RAM strobes.
module host_reg_if
   import gfx_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned COLS        = COLS_DEF,
   parameter int unsigned ROWS        = ROWS_DEF,
   parameter int unsigned ADDR_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bus_clk,
   input  logic              bus_cs_n,
   input  logic [3:0]        bus_rs,
   input  logic              bus_we_n,
   input  logic [7:0]        bus_data_i,
   output logic [7:0]        bus_data_o,
   output logic              bus_data_oe,
   input  logic              vblank_i,
   output logic [1:0]        mode_o,
   output logic              scr_wr_en,
   output logic [ADDR_W-1:0] scr_wr_addr,
   output logic [7:0]        scr_wr_data
);

   logic        bus_act;
   logic [1:0]  ctl_s;
   logic [11:0] dat_s;
   logic        act_s, we_n_s, act_q;
   logic [3:0]  rs_s;
   logic [7:0]  data_s;

   logic [3:0]  hold_rs;
   logic        hold_we_n;
   logic [7:0]  hold_data;
   logic        commit;

   wr_state_e   state;
   logic [7:0]  mode_reg, data_reg, addr_lo, addr_hi;
   logic        wr_pending, vblank_q;

   logic [6:0]  col_cur, col_nxt;
   logic [7:0]  row_nxt;
   logic [15:0] lin_nxt, addr_cur;
   logic [7:0]  rd_mux;

   assign bus_act     = bus_clk & ~bus_cs_n;
   assign bus_data_oe = bus_clk & ~bus_cs_n & bus_we_n;

   bus_sync #(.WIDTH(2), .STAGES(SYNC_STAGES)) u_sync_ctl (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({bus_act, bus_we_n}),
      .q     (ctl_s)
   );

   bus_sync #(.WIDTH(12), .STAGES(SYNC_STAGES)) u_sync_dat (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({bus_rs, bus_data_i}),
      .q     (dat_s)
   );

   assign act_s  = ctl_s[1];
   assign we_n_s = ctl_s[0];
   assign rs_s   = dat_s[11:8];
   assign data_s = dat_s[7:0];

   // Fields are held from the last active sample so the commit on the
   // falling edge of act sees settled values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_q     <= 1'b0;
         hold_rs   <= '0;
         hold_we_n <= 1'b1;
         hold_data <= '0;
      end else begin
         act_q <= act_s;
         if (act_s) begin
            hold_rs   <= rs_s;
            hold_we_n <= we_n_s;
            hold_data <= data_s;
         end
      end
   end

   assign commit = act_q & ~act_s & ~hold_we_n;

   always_comb begin
      lin_nxt  = {addr_hi, addr_lo} + 16'd1;
      col_cur  = addr_lo[6:0];
      col_nxt  = col_cur + 7'd1;
      row_nxt  = addr_hi + 8'd1;
      if (32'(col_cur) >= COLS - 1) begin
         col_nxt = '0;
         row_nxt = (32'(addr_hi) >= ROWS - 1) ? '0 : addr_hi + 8'd1;
      end else begin
         row_nxt = addr_hi;
      end
      addr_cur = mode_reg[MODE_LINEAR_BIT] ? {addr_hi, addr_lo} : xy_addr(addr_hi, col_cur);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= WR_IDLE;
         mode_reg    <= '0;
         data_reg    <= '0;
         addr_lo     <= '0;
         addr_hi     <= '0;
         wr_pending  <= 1'b0;
         scr_wr_en   <= 1'b0;
         scr_wr_addr <= '0;
         scr_wr_data <= '0;
      end else begin
         case (state)
            WR_IDLE: begin
               if (commit && hold_rs == REG_DATA) begin
                  scr_wr_data <= hold_data;
                  scr_wr_addr <= ADDR_W'(addr_cur);
                  scr_wr_en   <= 1'b1;
                  wr_pending  <= 1'b1;
                  state       <= WR_STROBE;
               end
            end
            WR_STROBE: begin
               scr_wr_en <= 1'b0;
               if (mode_reg[MODE_AUTOINC_BIT]) begin
                  state <= WR_INC;
               end else begin
                  wr_pending <= 1'b0;
                  state      <= WR_IDLE;
               end
            end
            WR_INC: begin
               if (mode_reg[MODE_LINEAR_BIT]) begin
                  {addr_hi, addr_lo} <= lin_nxt;
               end else begin
                  addr_hi <= row_nxt;
                  addr_lo <= {addr_lo[7], col_nxt};
               end
               wr_pending <= 1'b0;
               state      <= WR_IDLE;
            end
            default: begin
               scr_wr_en  <= 1'b0;
               wr_pending <= 1'b0;
               state      <= WR_IDLE;
            end
         endcase

         // A host write wins over the cursor update should the two ever meet
         if (commit) begin
            case (hold_rs)
               REG_MODE:    mode_reg <= hold_data;
               REG_DATA:    data_reg <= hold_data;
               REG_ADDR_LO: addr_lo  <= hold_data;
               REG_ADDR_HI: addr_hi  <= hold_data;
               default:     ;
            endcase
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      case (rs_s)
         REG_MODE:    rd_mux = mode_reg;
         REG_DATA:    rd_mux = data_reg;
         REG_ADDR_LO: rd_mux = addr_lo;
         REG_ADDR_HI: rd_mux = addr_hi;
         REG_STATUS: begin
            rd_mux[STATUS_VBLANK_BIT] = vblank_q;
            rd_mux[STATUS_PEND_BIT]   = wr_pending;
         end
         default:     rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vblank_q   <= 1'b0;
         bus_data_o <= '0;
      end else begin
         vblank_q   <= vblank_i;
         bus_data_o <= rd_mux;
      end
   end

   assign mode_o = mode_reg[1:0];

endmodule

// File: doc/host_reg_if.md
Name: host_reg_if

Overview:
- Host-side front end of the graphics adapter. It sits upstream of the screen RAM write port and the text/bitmap controllers.
- Receives 1 MHz host bus cycles (cs/rs/we/data) asynchronously and synchronizes them into the pixel-fabric clock domain.
- Holds the control register file and turns writes to the DATA register into single-cycle screen RAM write strobes, with optional cursor auto-increment.
- Serves host register reads.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the bus synchronizers (min 2)
- COLS, 80, text columns in xy mode
- ROWS, 60, text rows in xy mode
- ADDR_W, 16, screen RAM address width

Ports:
- clk  in  1  fabric clock (same clock as screen RAM/controllers)
- rst_n  in  1  asynchronous active-low reset
- bus_clk  in  1  host 1 MHz phase clock (asynchronous to clk)
- bus_cs_n  in  1  chip select, active low
- bus_rs  in  4  register select
- bus_we_n  in  1  write enable, active low
- bus_data_i  in  8  host write data
- bus_data_o  out  8  host read data
- bus_data_oe  out  1  drive enable for the tristate data pad
- vblank_i  in  1  vertical blank flag from the timing generator (clk domain)
- mode_o  out  2  display mode: 0 mono text, 1 colour text, 2 low-res bitmap, 3 high-res bitmap
- scr_wr_en  out  1  one-clk write strobe to screen RAM
- scr_wr_addr  out  ADDR_W  screen RAM write address
- scr_wr_data  out  8  screen RAM write data

Behaviour:
- bus_act = bus_clk & ~bus_cs_n (combinational). It is synchronized through SYNC_STAGES FFs together with bus_we_n, bus_rs and bus_data_i.
- Capture: while synced act = 1, the holding regs hold_rs, hold_we_n and hold_data load the synced fields every clk.
- Commit: on the 1→0 edge of synced act (end of bus phase), a write commits if hold_we_n = 0. Exactly one commit occurs per bus cycle.
- Commit latency: ≤ SYNC_STAGES+1 clk after the bus_clk fall.
- Registers (index: function, reset 0):
  - 0 MODE: [1:0] mode, [7] auto-increment enable. Other bits read back as written.
  - 1 DATA: write-only, triggers a screen write. Reads return the last written value.
  - 3 ADDR_LO
  - 4 ADDR_HI
  - 5 STATUS, read-only: [0] vblank_i synced, [7] wr_pending. Writes are ignored.
  - 2, 6–15: reserved. Writes are ignored; reads return 0x00.
- Address formation:
  - MODE[1] = 0 (xy): col = ADDR_LO[6:0], row = ADDR_HI; scr_wr_addr = {1'b0, row, col}.
  - MODE[1] = 1 (linear): scr_wr_addr = {ADDR_HI, ADDR_LO}.
- DATA write state machine (IDLE → STROBE → INC → IDLE):
  - IDLE: on a commit to reg 1, set scr_wr_data = hold_data, latch scr_wr_addr, set wr_pending = 1, go to STROBE.
  - STROBE: scr_wr_en = 1 for exactly one clk. Go to INC if MODE[7] = 1, else to IDLE.
  - INC, linear mode: {ADDR_HI, ADDR_LO} += 1, wrapping 0xFFFF → 0x0000.
  - INC, xy mode: col += 1. If col = COLS-1, col → 0 and row += 1. If row = ROWS-1 with col = COLS-1, both → 0. A col already ≥ COLS is treated as COLS-1 (wraps on next increment).
  - wr_pending clears on return to IDLE.
- Simultaneous events: bus commits are ≥ 1 µs apart, so the state machine always returns to IDLE before the next commit. A commit arriving outside IDLE (only possible if clk < 4 MHz) is dropped, and STATUS[7] stays set until the machine returns to IDLE.
- Reads:
  - bus_data_oe = bus_clk & ~bus_cs_n & bus_we_n (combinational).
  - bus_data_o is registered each clk from the register mux, indexed by synced bus_rs.
  - Data is valid ≤ SYNC_STAGES+1 clk after rs settles.
- Output reset values: mode_o = 0, scr_wr_en = 0, scr_wr_addr = 0, scr_wr_data = 0, bus_data_o = 0, all registers 0.
- Reset mid-operation: asynchronous assert aborts any strobe (scr_wr_en drops immediately) and returns the state machine to IDLE. The synchronizers clear, so a bus cycle in flight at deassert is not committed unless its falling edge occurs after reset release.

Decomposition:
- Shared package gfx_pkg holds:
  - register index constants: REG_MODE = 0, REG_DATA = 1, REG_ADDR_LO = 3, REG_ADDR_HI = 4, REG_STATUS = 5
  - mode encodings: MODE_MTXT, MODE_CTXT, MODE_LBMP, MODE_HBMP
  - MODE/STATUS bit positions
  - COLS/ROWS defaults
- One sub-module: bus_sync, a parameterized-width, SYNC_STAGES-deep synchronizer with async active-low reset. It is instantiated for the control bits and for the rs/data bundle.

Test Plan:
- Reset: hold rst_n = 0 mid-stream → all outputs 0, scr_wr_en never asserts. Release, then read reg 0 → 0x00.
- Linear write with auto-increment:
  - Stimulus: MODE = 0x82, ADDR_HI = 0x12, ADDR_LO = 0x34, DATA = 0x41.
  - Required: one scr_wr_en pulse with addr 0x1234 and data 0x41; afterwards ADDR_LO reads 0x35.
- Linear wrap:
  - Stimulus: ADDR = 0xFFFF with auto-increment, write DATA = 0x55.
  - Required: pulse at 0xFFFF, then ADDR_HI/ADDR_LO read 0x00/0x00.
- xy wrap:
  - Stimulus: MODE = 0x80, ADDR_HI = 59, ADDR_LO = 79, DATA = 0x20.
  - Required: write addr = {0, 59, 79} = 0x1DCF; afterwards row = 0, col = 0.
- No auto-increment:
  - Stimulus: MODE = 0x00, ADDR = row 2 / col 5, two DATA writes 0x10 then 0x11.
  - Required: two pulses, both at addr 0x0105; ADDR unchanged.
- Reads and reserved registers:
  - Stimulus: write reg 6 = 0xAA, then read reg 6 → 0x00. Hold vblank_i = 1 and read reg 5.
  - Required: read of reg 5 → 0x01. bus_data_oe is high only while bus_clk = 1, cs_n = 0 and we_n = 1.
- Drive bus_clk at 1 MHz against clk at 25 MHz and 50 MHz in all scenarios, with random phase offset.
